stream_demux: RTL and testbench

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux_if.sv | 31 +++
 rtl/stream_demux.sv | 74 +++++++
 tb/tb_stream_demux.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_if.sv
// rtl/stream_demux_if.sv - handshake and status bundle for stream_demux
interface stream_demux_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2,
  parameter int CNT_W = 16
);
  localparam int N = 2**SEL_W;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [SEL_W-1:0]     in_sel;
  logic                 in_bcast;
  logic [N-1:0]         out_valid;
  logic [N-1:0]         out_ready;
  logic [N*WIDTH-1:0]   out_data;
  logic                 cnt_clr;
  logic [N*CNT_W-1:0]   cnt;

  // Demux side: consumes the upstream stream and produces the per-channel lanes
  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready, cnt_clr,
    output in_ready, out_valid, out_data, cnt
  );

  // Environment side: drives upstream and downstream controls
  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready, cnt_clr,
    input  in_ready, out_valid, out_data, cnt
  );
endinterface

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - one-to-N stream demultiplexer with broadcast and per-channel counters
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  stream_demux_if.slave bus
);
  localparam int N = 2**SEL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N-1:0]            valid_q;
  logic [N-1:0][WIDTH-1:0] data_q;
  logic [N-1:0][CNT_W-1:0] cnt_q;
  logic [N-1:0]            free;
  logic [N-1:0]            drain;
  logic [N-1:0]            load;
  logic                    in_ready;

  // A channel is free when empty or being drained this cycle; broadcast needs every channel free
  always_comb begin
    free     = ~valid_q | bus.out_ready;
    drain    = valid_q & bus.out_ready;
    in_ready = bus.in_bcast ? (&free) : free[bus.in_sel];
    load     = '0;
    if (bus.in_valid && in_ready) begin
      if (bus.in_bcast) begin
        load = '1;
      end else begin
        load[bus.in_sel] = 1'b1;
      end
    end
  end

  // Output registers: a load takes precedence over a drain so a slot refills with no bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= bus.in_data;
        end else if (drain[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  // Delivered-transfer counters: clear beats increment, saturate instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (bus.cnt_clr) begin
          cnt_q[k] <= '0;
        end else if (drain[k] && (cnt_q[k] != CNT_MAX)) begin
          cnt_q[k] <= cnt_q[k] + CNT_ONE;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.cnt       = cnt_q;
endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - self-checking bench for stream_demux
module tb_stream_demux;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] sb [N][$];
  int         exp_cnt [N];

  stream_demux_if #(.WIDTH(8), .SEL_W(2), .CNT_W(16)) m();
  stream_demux_if #(.WIDTH(8), .SEL_W(2), .CNT_W(4))  s();

  stream_demux #(.WIDTH(8), .SEL_W(2), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(m.slave));
  stream_demux #(.WIDTH(8), .SEL_W(2), .CNT_W(4))  dut_sat (.clk(clk), .rst(rst), .bus(s.slave));

  always #5 clk = ~clk;

  function automatic logic [7:0] lane_m(input int k);
    return m.out_data[k*8 +: 8];
  endfunction

  function automatic logic [15:0] cnt_m(input int k);
    return m.cnt[k*16 +: 16];
  endfunction

  task automatic idle_all();
    m.in_valid = 0; m.in_data = 0; m.in_sel = 0; m.in_bcast = 0; m.out_ready = 0; m.cnt_clr = 0;
    s.in_valid = 0; s.in_data = 0; s.in_sel = 0; s.in_bcast = 0; s.out_ready = 0; s.cnt_clr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    #12;
    checks++; if (m.out_valid !== 4'b0000) begin failures++; $display("FAIL reset_out_valid got=%b exp=0000", m.out_valid); end
    checks++; if (m.cnt !== 64'd0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", m.cnt); end
    m.in_sel = 2'd3; #1;
    checks++; if (m.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_uni got=%b exp=1", m.in_ready); end
    m.in_bcast = 1'b1; #1;
    checks++; if (m.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_bcast got=%b exp=1", m.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    idle_all();
  endtask

  task automatic test_unicast();
    @(negedge clk);
    m.out_ready = 4'b0000; m.in_valid = 1; m.in_sel = 2'd2; m.in_bcast = 0; m.in_data = 8'hA5; #1;
    checks++; if (m.in_ready !== 1'b1) begin failures++; $display("FAIL uni_first_ready got=%b exp=1", m.in_ready); end
    @(negedge clk);
    m.in_data = 8'h5A; #1;
    checks++; if (m.out_valid !== 4'b0100) begin failures++; $display("FAIL uni_out_valid got=%b exp=0100", m.out_valid); end
    checks++; if (lane_m(2) !== 8'hA5) begin failures++; $display("FAIL uni_out_data got=%h exp=a5", lane_m(2)); end
    checks++; if (m.in_ready !== 1'b0) begin failures++; $display("FAIL uni_second_ready got=%b exp=0", m.in_ready); end
    @(negedge clk);
    m.in_valid = 0; #1;
    checks++; if (m.out_valid !== 4'b0100 || lane_m(2) !== 8'hA5) begin failures++; $display("FAIL uni_hold got=%b/%h exp=0100/a5", m.out_valid, lane_m(2)); end
    m.out_ready = 4'b0100;
    @(negedge clk);
    m.out_ready = 4'b0000; #1;
    checks++; if (m.out_valid !== 4'b0000) begin failures++; $display("FAIL uni_drain got=%b exp=0000", m.out_valid); end
    checks++; if (cnt_m(2) !== 16'd1) begin failures++; $display("FAIL uni_cnt got=%0d exp=1", cnt_m(2)); end
  endtask

  task automatic test_bcast_blocked();
    @(negedge clk);
    m.in_valid = 1; m.in_sel = 2'd1; m.in_bcast = 0; m.in_data = 8'h11; m.out_ready = 0;
    @(negedge clk);
    m.in_bcast = 1; m.in_data = 8'h3C; #1;
    checks++; if (m.in_ready !== 1'b0) begin failures++; $display("FAIL bc_blocked_ready got=%b exp=0", m.in_ready); end
    @(negedge clk); #1;
    checks++; if (m.out_valid !== 4'b0010 || lane_m(1) !== 8'h11) begin failures++; $display("FAIL bc_no_partial got=%b/%h exp=0010/11", m.out_valid, lane_m(1)); end
    m.out_ready = 4'b0010; #1;
    checks++; if (m.in_ready !== 1'b1) begin failures++; $display("FAIL bc_unblocked_ready got=%b exp=1", m.in_ready); end
    @(negedge clk);
    m.in_valid = 0; m.out_ready = 0; #1;
    checks++; if (m.out_valid !== 4'b1111) begin failures++; $display("FAIL bc_out_valid got=%b exp=1111", m.out_valid); end
    for (int k = 0; k < N; k++) begin
      checks++; if (lane_m(k) !== 8'h3C) begin failures++; $display("FAIL bc_lane%0d got=%h exp=3c", k, lane_m(k)); end
    end
    checks++; if (cnt_m(1) !== 16'd1) begin failures++; $display("FAIL bc_cnt1 got=%0d exp=1", cnt_m(1)); end
    m.out_ready = 4'b1111;
    @(negedge clk);
    m.out_ready = 0; #1;
    checks++; if (m.out_valid !== 4'b0000) begin failures++; $display("FAIL bc_drain got=%b exp=0000", m.out_valid); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    m.cnt_clr = 1;
    @(negedge clk);
    m.cnt_clr = 0; #1;
    checks++; if (m.cnt !== 64'd0) begin failures++; $display("FAIL b2b_clr got=%h exp=0", m.cnt); end
    m.out_ready = 4'b0001; m.in_valid = 1; m.in_sel = 2'd0; m.in_bcast = 0;
    for (int i = 1; i <= 16; i++) begin
      m.in_data = 8'(i); #1;
      checks++; if (m.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, m.in_ready); end
      if (i > 1) begin
        checks++; if (m.out_valid[0] !== 1'b1 || lane_m(0) !== 8'(i - 1)) begin failures++; $display("FAIL b2b_out_%0d got=%b/%h exp=1/%h", i, m.out_valid[0], lane_m(0), 8'(i - 1)); end
      end
      @(negedge clk);
    end
    m.in_valid = 0; #1;
    checks++; if (m.out_valid[0] !== 1'b1 || lane_m(0) !== 8'h10) begin failures++; $display("FAIL b2b_last got=%b/%h exp=1/10", m.out_valid[0], lane_m(0)); end
    @(negedge clk);
    m.out_ready = 0; #1;
    checks++; if (m.out_valid !== 4'b0000) begin failures++; $display("FAIL b2b_empty got=%b exp=0000", m.out_valid); end
    checks++; if (cnt_m(0) !== 16'd16) begin failures++; $display("FAIL b2b_cnt got=%0d exp=16", cnt_m(0)); end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    s.in_valid = 1; s.in_sel = 2'd3; s.in_bcast = 0; s.out_ready = 4'b1000;
    for (int i = 0; i < 21; i++) begin
      s.in_data = 8'(i);
      @(negedge clk);
    end
    s.in_valid = 0; #1;
    checks++; if (s.cnt[12 +: 4] !== 4'd15) begin failures++; $display("FAIL sat_cnt got=%0d exp=15", s.cnt[12 +: 4]); end
    s.cnt_clr = 1;
    @(negedge clk);
    s.cnt_clr = 0; s.out_ready = 0; #1;
    checks++; if (s.cnt[12 +: 4] !== 4'd0) begin failures++; $display("FAIL sat_clr got=%0d exp=0", s.cnt[12 +: 4]); end
    checks++; if (s.out_valid !== 4'b0000) begin failures++; $display("FAIL sat_drain got=%b exp=0000", s.out_valid); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    m.in_valid = 1; m.in_bcast = 1; m.in_data = 8'hC7; m.out_ready = 0;
    @(negedge clk);
    m.in_valid = 0; #1;
    checks++; if (m.out_valid !== 4'b1111) begin failures++; $display("FAIL ar_pre_valid got=%b exp=1111", m.out_valid); end
    checks++; if (cnt_m(0) !== 16'd16) begin failures++; $display("FAIL ar_pre_cnt got=%0d exp=16", cnt_m(0)); end
    #1 rst = 1'b1;
    #1;
    checks++; if (m.out_valid !== 4'b0000) begin failures++; $display("FAIL ar_valid got=%b exp=0000", m.out_valid); end
    checks++; if (m.cnt !== 64'd0) begin failures++; $display("FAIL ar_cnt got=%h exp=0", m.cnt); end
    checks++; if (m.out_data !== 32'd0) begin failures++; $display("FAIL ar_data got=%h exp=0", m.out_data); end
    checks++; if (m.in_ready !== 1'b1) begin failures++; $display("FAIL ar_ready got=%b exp=1", m.in_ready); end
    #1 rst = 1'b0;
    @(negedge clk);
    m.in_valid = 1; m.in_bcast = 0; m.in_sel = 2'd1; m.in_data = 8'h77; #1;
    checks++; if (m.in_ready !== 1'b1) begin failures++; $display("FAIL ar_post_ready got=%b exp=1", m.in_ready); end
    @(negedge clk);
    m.in_valid = 0; #1;
    checks++; if (m.out_valid !== 4'b0010 || lane_m(1) !== 8'h77) begin failures++; $display("FAIL ar_post_out got=%b/%h exp=0010/77", m.out_valid, lane_m(1)); end
    m.out_ready = 4'b1111;
    @(negedge clk);
    m.out_ready = 0;
  endtask

  task automatic test_random();
    logic exp_rdy;
    logic all_free;
    @(negedge clk);
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      sb[k].delete();
      exp_cnt[k] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      m.in_valid = ($urandom_range(0, 9) < 7);
      m.in_bcast = ($urandom_range(0, 9) < 2);
      m.in_sel   = 2'($urandom_range(0, 3));
      m.in_data  = 8'($urandom);
      m.cnt_clr  = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < N; k++) m.out_ready[k] = ($urandom_range(0, 9) < 6);
      #1;
      all_free = 1'b1;
      for (int k = 0; k < N; k++) if (sb[k].size() != 0 && !m.out_ready[k]) all_free = 1'b0;
      if (m.in_bcast) exp_rdy = all_free;
      else exp_rdy = (sb[m.in_sel].size() == 0) || m.out_ready[m.in_sel];
      checks++; if (m.in_ready !== exp_rdy) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, m.in_ready, exp_rdy); end
      for (int k = 0; k < N; k++) begin
        checks++; if (m.out_valid[k] !== (sb[k].size() != 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d ch=%0d got=%b exp=%b", cyc, k, m.out_valid[k], sb[k].size() != 0); end
        if (sb[k].size() != 0) begin
          checks++; if (lane_m(k) !== sb[k][0]) begin failures++; $display("FAIL rnd_data cyc=%0d ch=%0d got=%h exp=%h", cyc, k, lane_m(k), sb[k][0]); end
        end
        checks++; if (cnt_m(k) !== 16'(exp_cnt[k])) begin failures++; $display("FAIL rnd_cnt cyc=%0d ch=%0d got=%0d exp=%0d", cyc, k, cnt_m(k), exp_cnt[k]); end
      end
      for (int k = 0; k < N; k++) begin
        if (sb[k].size() != 0 && m.out_ready[k]) begin
          void'(sb[k].pop_front());
          exp_cnt[k]++;
        end
        if (m.cnt_clr) exp_cnt[k] = 0;
        if (m.in_valid && exp_rdy && (m.in_bcast || m.in_sel == 2'(k))) sb[k].push_back(m.in_data);
      end
    end
    @(negedge clk);
    idle_all();
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_bcast_blocked();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
